// File: rtl/data_bus_bridge_pkg.sv
// Shared types and helpers for the data-side OBI bus bridge.
// Holds the FSM state encoding and the latched request payload.
package data_bus_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT_RESP,
    COMPLETE,
    DRAIN
  } busBridgeState_;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] storeData;
    logic [BE_W-1:0]   byteEnable;
    logic              write;
  } busRequest_;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bus addresses are always word aligned; lane selection travels in byteEnable.
  function automatic logic [ADDR_W-1:0] wordAlign(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/data_bus_bridge_watchdog.sv
// Saturating cycle counter with a registered expiry flag.
// Shared between the access timeout and the post-timeout drain window.
module bus_watchdog
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;

  // Saturate rather than wrap so a stuck enable can never re-arm the flag.
  always_comb begin
    countNext = count;
    if (clear) begin
      countNext = '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      countNext = count + CNT_W'(1);
    end
  end

  // expired always mirrors (count >= limit) for the count it is registered with.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= countNext;
      expired <= (countNext >= limit);
    end
  end

endmodule

// File: rtl/data_bus_bridge.sv
// Memory-stage load/store port to OBI-style req/gnt/rvalid bus bridge.
// A watchdog aborts hung accesses with busError and drains any late response.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DRAIN_CYCLES   = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] storeData,
  input  logic [BE_W-1:0]   byteEnable,
  input  logic              storeValid,
  input  logic              loadValid,
  output logic [DATA_W-1:0] loadData,
  output logic              loadDataValid,
  output logic              storeComplete,
  output logic              busError,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int unsigned CNT_W = $clog2(maxOf(TIMEOUT_CYCLES, DRAIN_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LIMIT   = CNT_W'(DRAIN_CYCLES - 1);

  busBridgeState_ state;
  busBridgeState_ stateNext;
  busRequest_     pending;
  busRequest_     pendingNext;

  logic              drainPending;
  logic              drainPendingNext;
  logic              busReqNext;
  logic [DATA_W-1:0] loadDataNext;
  logic              loadDataValidNext;
  logic              storeCompleteNext;
  logic              busErrorNext;

  logic              finish;
  logic              finishErr;
  logic [DATA_W-1:0] finishData;

  logic              wdClear;
  logic              wdEnable;
  logic [CNT_W-1:0]  wdLimit;
  logic              wdExpired;

  bus_watchdog #(
    .CNT_W (CNT_W)
  ) uWatchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdClear),
    .enable  (wdEnable),
    .limit   (wdLimit),
    .expired (wdExpired)
  );

  // Bus address phase is a straight view of the latched request register.
  assign bus_addr  = wordAlign(pending.address);
  assign bus_we    = pending.write;
  assign bus_be    = pending.byteEnable;
  assign bus_wdata = pending.storeData;

  // Next-state and next-output logic; completions are staged on entry to COMPLETE.
  always_comb begin
    stateNext         = state;
    pendingNext       = pending;
    drainPendingNext  = drainPending;
    busReqNext        = 1'b0;
    loadDataNext      = loadData;
    loadDataValidNext = 1'b0;
    storeCompleteNext = 1'b0;
    busErrorNext      = 1'b0;
    finish            = 1'b0;
    finishErr         = 1'b0;
    finishData        = '0;
    wdClear           = 1'b0;
    wdEnable          = 1'b0;
    wdLimit           = ((state == DRAIN) || ((state == COMPLETE) && drainPending))
                        ? DRAIN_LIMIT : TIMEOUT_LIMIT;

    case (state)
      IDLE: begin
        if (storeValid || loadValid) begin
          pendingNext = '{address:    address,
                          storeData:  storeData,
                          byteEnable: byteEnable,
                          write:      storeValid};
          busReqNext       = 1'b1;
          wdClear          = 1'b1;
          drainPendingNext = 1'b0;
          stateNext        = REQUEST;
        end
      end

      REQUEST: begin
        wdEnable = 1'b1;
        // A grant in the timeout cycle still leaves a response in flight.
        if (wdExpired) begin
          finish           = 1'b1;
          finishErr        = 1'b1;
          drainPendingNext = bus_gnt;
          stateNext        = COMPLETE;
        end else if (bus_gnt) begin
          stateNext = WAIT_RESP;
        end else begin
          busReqNext = 1'b1;
        end
      end

      WAIT_RESP: begin
        wdEnable = 1'b1;
        if (bus_rvalid) begin
          finish     = 1'b1;
          finishErr  = bus_err;
          finishData = bus_rdata;
          stateNext  = COMPLETE;
        end else if (wdExpired) begin
          finish           = 1'b1;
          finishErr        = 1'b1;
          drainPendingNext = 1'b1;
          stateNext        = COMPLETE;
        end
      end

      COMPLETE: begin
        if (drainPending) begin
          wdClear   = 1'b1;
          stateNext = DRAIN;
        end else begin
          stateNext = IDLE;
        end
      end

      DRAIN: begin
        wdEnable = 1'b1;
        if (bus_rvalid || wdExpired) begin
          drainPendingNext = 1'b0;
          stateNext        = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (finish) begin
      loadDataValidNext = ~pending.write;
      storeCompleteNext = pending.write;
      busErrorNext      = finishErr;
      if (!pending.write) begin
        loadDataNext = finishData;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= '0;
      drainPending  <= 1'b0;
      bus_req       <= 1'b0;
      loadData      <= '0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      busError      <= 1'b0;
    end else begin
      state         <= stateNext;
      pending       <= pendingNext;
      drainPending  <= drainPendingNext;
      bus_req       <= busReqNext;
      loadData      <= loadDataNext;
      loadDataValid <= loadDataValidNext;
      storeComplete <= storeCompleteNext;
      busError      <= busErrorNext;
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Scenario bench for data_bus_bridge with a completion scoreboard.
module tb_data_bus_bridge;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned DRAIN   = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] storeData = '0;
  logic [3:0]  byteEnable = '0;
  logic        storeValid = 1'b0;
  logic        loadValid = 1'b0;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        busError;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  typedef struct packed {
    logic        isLoad;
    logic        err;
    logic [31:0] data;
  } expect_t;

  expect_t sbQueue[$];
  expect_t sbHead;
  int checks = 0;
  int failures = 0;

  data_bus_bridge #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .DRAIN_CYCLES   (DRAIN)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .storeData     (storeData),
    .byteEnable    (byteEnable),
    .storeValid    (storeValid),
    .loadValid     (loadValid),
    .loadData      (loadData),
    .loadDataValid (loadDataValid),
    .storeComplete (storeComplete),
    .busError      (busError),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err)
  );

  always #5 clock = ~clock;

  // Every completion pulse must match the oldest expected completion.
  always @(negedge clock) begin
    if (!reset && (loadDataValid || storeComplete)) begin
      checks++;
      if (sbQueue.size() == 0) begin
        failures++;
        $display("FAIL unexpected_completion loadDataValid=%0b storeComplete=%0b busError=%0b",
                 loadDataValid, storeComplete, busError);
      end else begin
        sbHead = sbQueue.pop_front();
        if (loadDataValid !== sbHead.isLoad || storeComplete !== ~sbHead.isLoad ||
            busError !== sbHead.err || (sbHead.isLoad && loadData !== sbHead.data)) begin
          failures++;
          $display("FAIL scoreboard got ld=%0b st=%0b err=%0b data=%h expected ld=%0b err=%0b data=%h",
                   loadDataValid, storeComplete, busError, loadData,
                   sbHead.isLoad, sbHead.err, sbHead.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pushExp(input logic isLoad, input logic err, input logic [31:0] data);
    expect_t e;
    e.isLoad = isLoad;
    e.err    = err;
    e.data   = data;
    sbQueue.push_back(e);
  endtask

  // Grant the pending request, then return a response on the next cycle.
  task automatic serveAccess(input logic [31:0] data, input logic err);
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = data;
    bus_err    = err;
    tick();
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
  endtask

  task automatic waitCompletion(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (loadDataValid || storeComplete) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, loadData,
         loadDataValid, storeComplete, busError} !== 105'd0) begin
      failures++;
      $display("FAIL reset_outputs req=%0b we=%0b be=%h addr=%h wdata=%h ld=%h pulses=%0b%0b%0b expected all zero",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, loadData,
               loadDataValid, storeComplete, busError);
    end
  endtask

  task automatic test_load_min_latency;
    address = 32'h0000_2000;
    loadValid = 1'b1;
    pushExp(1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h0000_2000) begin
      failures++;
      $display("FAIL load_request req=%0b we=%0b addr=%h expected 1 0 00002000", bus_req, bus_we, bus_addr);
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    checks++;
    if (bus_req !== 1'b0 || loadDataValid !== 1'b0) begin
      failures++;
      $display("FAIL load_gnt_drop req=%0b ldv=%0b expected 0 0", bus_req, loadDataValid);
    end
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEADBEEF;
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if (loadDataValid !== 1'b1 || loadData !== 32'hDEADBEEF || busError !== 1'b0) begin
      failures++;
      $display("FAIL load_complete ldv=%0b data=%h err=%0b expected 1 deadbeef 0",
               loadDataValid, loadData, busError);
    end
    loadValid = 1'b0;
    tick();
    checks++;
    if (loadDataValid !== 1'b0) begin
      failures++;
      $display("FAIL load_pulse_width ldv=%0b expected 0", loadDataValid);
    end
  endtask

  task automatic test_store_delayed_gnt;
    int reqCycles;
    int pulses;
    address    = 32'h0000_1003;
    byteEnable = 4'b1000;
    storeData  = 32'hAB00_0000;
    storeValid = 1'b1;
    pushExp(1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (bus_addr !== 32'h0000_1000 || bus_be !== 4'b1000 || bus_wdata !== 32'hAB00_0000 || bus_we !== 1'b1) begin
      failures++;
      $display("FAIL store_addr_phase addr=%h be=%b wdata=%h we=%0b expected 00001000 1000 ab000000 1",
               bus_addr, bus_be, bus_wdata, bus_we);
    end
    reqCycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus_req) reqCycles++;
      tick();
    end
    if (bus_req) reqCycles++;
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    checks++;
    if (reqCycles != 6 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL store_req_hold cycles=%0d req_after=%0b expected 6 0", reqCycles, bus_req);
    end
    tick();
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    checks++;
    if (storeComplete !== 1'b1 || loadDataValid !== 1'b0 || busError !== 1'b0 || loadData !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL store_complete st=%0b ldv=%0b err=%0b ld=%h expected 1 0 0 deadbeef",
               storeComplete, loadDataValid, busError, loadData);
    end
    storeValid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (storeComplete) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL store_single_pulse extra=%0d expected 0", pulses);
    end
  endtask

  task automatic test_slave_error;
    address = 32'h0000_3000;
    loadValid = 1'b1;
    pushExp(1'b1, 1'b1, 32'hBAD0_BAD0);
    tick();
    serveAccess(32'hBAD0_BAD0, 1'b1);
    checks++;
    if (loadDataValid !== 1'b1 || busError !== 1'b1 || loadData !== 32'hBAD0_BAD0) begin
      failures++;
      $display("FAIL slave_error ldv=%0b err=%0b data=%h expected 1 1 bad0bad0",
               loadDataValid, busError, loadData);
    end
    address = 32'h0000_3004;
    tick();
    checks++;
    if (bus_req !== 1'b0 || loadDataValid !== 1'b0 || busError !== 1'b0) begin
      failures++;
      $display("FAIL complete_ignores_req req=%0b ldv=%0b err=%0b expected 0 0 0", bus_req, loadDataValid, busError);
    end
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0000_3004) begin
      failures++;
      $display("FAIL next_req_accept req=%0b addr=%h expected 1 00003004", bus_req, bus_addr);
    end
    pushExp(1'b1, 1'b0, 32'h1234_5678);
    serveAccess(32'h1234_5678, 1'b0);
    loadValid = 1'b0;
    tick();
  endtask

  task automatic test_timeout_no_gnt;
    int n;
    address = 32'h0000_4000;
    loadValid = 1'b1;
    pushExp(1'b1, 1'b1, 32'h0);
    tick();
    waitCompletion(n);
    checks++;
    if (n != int'(TIMEOUT) || busError !== 1'b1 || loadData !== 32'h0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_no_gnt cycles=%0d err=%0b data=%h req=%0b expected 8 1 00000000 0",
               n, busError, loadData, bus_req);
    end
    loadValid = 1'b0;
    tick();
    checks++;
    if (bus_req !== 1'b0 || loadDataValid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle req=%0b ldv=%0b expected 0 0", bus_req, loadDataValid);
    end
  endtask

  task automatic test_timeout_drain_rvalid;
    int n;
    int pulses;
    address = 32'h0000_5000;
    loadValid = 1'b1;
    pushExp(1'b1, 1'b1, 32'h0);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    waitCompletion(n);
    checks++;
    if (n != int'(TIMEOUT) - 1 || busError !== 1'b1 || loadData !== 32'h0) begin
      failures++;
      $display("FAIL timeout_wait_resp cycles=%0d err=%0b data=%h expected 7 1 00000000", n, busError, loadData);
    end
    loadValid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (loadDataValid || storeComplete) pulses++;
    end
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_5555;
    tick();
    bus_rvalid = 1'b0;
    if (loadDataValid || storeComplete) pulses++;
    address = 32'h0000_5100;
    loadValid = 1'b1;
    tick();
    checks++;
    if (pulses != 0 || loadData !== 32'h0 || bus_req !== 1'b1) begin
      failures++;
      $display("FAIL drain_swallow pulses=%0d data=%h req=%0b expected 0 00000000 1", pulses, loadData, bus_req);
    end
    pushExp(1'b1, 1'b0, 32'h0A0B_0C0D);
    serveAccess(32'h0A0B_0C0D, 1'b0);
    loadValid = 1'b0;
    tick();
  endtask

  task automatic test_drain_expiry;
    int n;
    address = 32'h0000_6000;
    loadValid = 1'b1;
    pushExp(1'b1, 1'b1, 32'h0);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    waitCompletion(n);
    loadValid = 1'b0;
    tick();
    address = 32'h0000_6100;
    loadValid = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus_req) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != int'(DRAIN) + 1 || bus_addr !== 32'h0000_6100) begin
      failures++;
      $display("FAIL drain_expiry req_after=%0d addr=%h expected 17 00006100", n, bus_addr);
    end
    pushExp(1'b1, 1'b0, 32'h600D_600D);
    serveAccess(32'h600D_600D, 1'b0);
    loadValid = 1'b0;
    tick();
  endtask

  task automatic test_both_valid_reset;
    address    = 32'h0000_7000;
    storeData  = 32'hCAFE_F00D;
    byteEnable = 4'hF;
    storeValid = 1'b1;
    loadValid  = 1'b1;
    tick();
    checks++;
    if (bus_we !== 1'b1 || bus_req !== 1'b1) begin
      failures++;
      $display("FAIL store_wins we=%0b req=%0b expected 1 1", bus_we, bus_req);
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, loadData,
         loadDataValid, storeComplete, busError} !== 105'd0) begin
      failures++;
      $display("FAIL async_reset req=%0b we=%0b be=%h addr=%h wdata=%h ld=%h expected all zero",
               bus_req, bus_we, bus_be, bus_addr, bus_wdata, loadData);
    end
    storeValid = 1'b0;
    loadValid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    address = 32'h0000_8000;
    loadValid = 1'b1;
    pushExp(1'b1, 1'b0, 32'h1111_2222);
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0000_8000) begin
      failures++;
      $display("FAIL post_reset_req req=%0b addr=%h expected 1 00008000", bus_req, bus_addr);
    end
    serveAccess(32'h1111_2222, 1'b0);
    loadValid  = 1'b0;
    address    = 32'h0000_8004;
    storeData  = 32'h0000_00EE;
    byteEnable = 4'b0001;
    storeValid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h0000_8004 || bus_wdata !== 32'h0000_00EE) begin
      failures++;
      $display("FAIL b2b_store req=%0b we=%0b addr=%h wdata=%h expected 1 1 00008004 000000ee",
               bus_req, bus_we, bus_addr, bus_wdata);
    end
    pushExp(1'b0, 1'b0, 32'h0);
    serveAccess(32'h0, 1'b0);
    checks++;
    if (storeComplete !== 1'b1 || loadData !== 32'h1111_2222) begin
      failures++;
      $display("FAIL b2b_complete st=%0b ld=%h expected 1 11112222", storeComplete, loadData);
    end
    storeValid = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_load_min_latency();
    test_store_delayed_gnt();
    test_slave_error();
    test_timeout_no_gnt();
    test_timeout_drain_rvalid();
    test_drain_expiry();
    test_both_valid_reset();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (sbQueue.size() != 0) begin
      failures++;
      $display("FAIL missing_completions pending=%0d expected 0", sbQueue.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
